// File: rtl/mac_pkg.sv
// Shared MAC package: FSM state type, default term count and the
// controller strobe bundle. Also imported by the datapath comparator so
// both sides agree on the terminal count.
package mac_pkg;

  localparam int MAC_N_TERMS_DEFAULT = 50;
  localparam int MAC_CNT_W           = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_WAIT_OP = 3'd2,
    ST_ACC     = 3'd3,
    ST_CHECK   = 3'd4,
    ST_OUTPUT  = 3'd5,
    ST_HOLD    = 3'd6
  } mac_state_t;

  // Moore strobes decoded from the current state.
  typedef struct packed {
    logic in_ready;
    logic ld_acc;
    logic count_en;
    logic ld_out;
    logic ld_count;
    logic dp_clr;
    logic res_valid;
  } mac_strb_t;

endpackage

// File: rtl/mac_term_counter.sv
// 8-bit term counter for the MAC controller.
//   clk, reset_n : clock, async active-low reset
//   clr          : synchronous clear (start of job)
//   en           : count one accumulated term
//   count        : current term count
//   at_term      : count == N_TERMS
module mac_term_counter
  import mac_pkg::*;
#(
  parameter int N_TERMS = MAC_N_TERMS_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 clr,
  input  logic                 en,
  output logic [MAC_CNT_W-1:0] count,
  output logic                 at_term
);

  localparam logic [MAC_CNT_W-1:0] TERM = MAC_CNT_W'(N_TERMS);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      count <= '0;
    else if (clr)
      count <= '0;
    else if (en && count != '1)  // saturate; a job never needs more than 255
      count <= count + 1'b1;
  end

  assign at_term = (count == TERM);

endmodule

// File: rtl/mac_controller.sv
// MAC job controller. Sequences the datapath through
// CLEAR -> (WAIT_OP -> ACC -> CHECK)* -> OUTPUT -> HOLD, one operand pair
// per term, and cross-checks the datapath terminal count against an
// internal term counter.
//   start/abort            : job request (IDLE only) / cancel
//   in_valid/in_ready      : operand pair handshake
//   tc                     : datapath terminal count
//   ld_a..ld_count, dp_clr : datapath strobes
//   busy, res_valid/res_ready, err : status, result handshake, sticky error
module mac_controller
  import mac_pkg::*;
#(
  parameter int N_TERMS = MAC_N_TERMS_DEFAULT
) (
  input  logic clk,
  input  logic reset_n,
  input  logic start,
  input  logic abort,
  input  logic in_valid,
  output logic in_ready,
  input  logic tc,
  output logic ld_a,
  output logic ld_b,
  output logic ld_acc,
  output logic ld_out,
  output logic count_en,
  output logic ld_count,
  output logic dp_clr,
  output logic busy,
  output logic res_valid,
  input  logic res_ready,
  output logic err
);

  mac_state_t           state, nxt;
  mac_strb_t            strb;
  logic                 abort_pend;
  logic [MAC_CNT_W-1:0] term_cnt;
  logic                 at_term;
  logic                 abort_hit;

  // abort is only honoured once a job is past its CLEAR
  assign abort_hit = abort && (state != ST_IDLE) && (state != ST_CLEAR);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= nxt;
  end

  always_comb begin
    nxt  = state;
    strb = '0;
    case (state)
      ST_IDLE:    if (start) nxt = ST_CLEAR;
      ST_CLEAR: begin
        strb.dp_clr = 1'b1;
        // an aborted job clears the datapath then parks
        nxt = abort_pend ? ST_IDLE : ST_WAIT_OP;
      end
      ST_WAIT_OP: begin
        strb.in_ready = 1'b1;
        if (in_valid) nxt = ST_ACC;
      end
      ST_ACC: begin
        strb.ld_acc   = 1'b1;
        strb.count_en = 1'b1;
        nxt = ST_CHECK;
      end
      ST_CHECK:   nxt = tc ? ST_OUTPUT : ST_WAIT_OP;
      ST_OUTPUT: begin
        strb.ld_out   = 1'b1;
        strb.ld_count = 1'b1;
        nxt = ST_HOLD;
      end
      ST_HOLD: begin
        strb.res_valid = 1'b1;
        if (res_ready) nxt = ST_IDLE;
      end
      default:    nxt = ST_IDLE;
    endcase
    if (abort_hit) nxt = ST_CLEAR;
  end

  // remembers that the upcoming CLEAR came from an abort
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)              abort_pend <= 1'b0;
    else if (abort_hit)        abort_pend <= 1'b1;
    else if (state == ST_CLEAR) abort_pend <= 1'b0;
  end

  mac_term_counter #(.N_TERMS(N_TERMS)) u_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (state == ST_CLEAR),
    .en      (state == ST_ACC),
    .count   (term_cnt),
    .at_term (at_term)
  );

  // sticky: datapath tc must agree with our own term count
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                              err <= 1'b0;
    else if (state == ST_CHECK && tc != at_term) err <= 1'b1;
  end

  assign in_ready  = strb.in_ready;
  assign ld_a      = in_valid && (state == ST_WAIT_OP);
  assign ld_b      = in_valid && (state == ST_WAIT_OP);
  assign ld_acc    = strb.ld_acc;
  assign count_en  = strb.count_en;
  assign ld_out    = strb.ld_out;
  assign ld_count  = strb.ld_count;
  assign dp_clr    = strb.dp_clr;
  assign res_valid = strb.res_valid;
  assign busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_mac_controller.sv
// Bench for mac_controller with a small behavioural MAC datapath.
module tb_mac_controller;
  import mac_pkg::*;

  localparam int N = MAC_N_TERMS_DEFAULT;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic start = 1'b0, abort = 1'b0, in_valid = 1'b0, res_ready = 1'b0;
  logic force_tc = 1'b0;
  logic in_ready, tc, ld_a, ld_b, ld_acc, ld_out, count_en, ld_count;
  logic dp_clr, busy, res_valid, err;

  logic [7:0]  a_in = '0, b_in = '0, a_q, b_q, dp_cnt, count_last;
  logic [21:0] acc, out_q;

  int hs_cnt = 0, acc_cnt = 0, out_cnt = 0;
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  mac_controller #(.N_TERMS(N)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .in_valid(in_valid), .in_ready(in_ready), .tc(tc),
    .ld_a(ld_a), .ld_b(ld_b), .ld_acc(ld_acc), .ld_out(ld_out),
    .count_en(count_en), .ld_count(ld_count), .dp_clr(dp_clr),
    .busy(busy), .res_valid(res_valid), .res_ready(res_ready), .err(err)
  );

  // behavioural datapath
  assign tc = (dp_cnt == 8'(N)) || force_tc;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dp_cnt <= '0; acc <= '0; a_q <= '0; b_q <= '0; out_q <= '0; count_last <= '0;
    end else if (dp_clr) begin
      dp_cnt <= '0; acc <= '0;
    end else begin
      if (ld_a)     a_q <= a_in;
      if (ld_b)     b_q <= b_in;
      if (ld_acc)   acc <= acc + 22'(a_q * b_q);
      if (count_en) dp_cnt <= dp_cnt + 8'd1;
      if (ld_out)   out_q <= acc;
      if (ld_count) count_last <= dp_cnt;
    end
  end

  always_ff @(posedge clk) begin
    if (in_valid && in_ready) hs_cnt <= hs_cnt + 1;
    if (ld_acc)               acc_cnt <= acc_cnt + 1;
    if (ld_out)               out_cnt <= out_cnt + 1;
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0] a, b;
    int gap_after, gap_len, force_at, hold_wait;
    int exp_out, exp_last, exp_cyc, exp_acc;
    logic exp_err;
  } vec_t;

  // Runs one job; cyc counts rising edges from the one that samples start
  // (cycle 1) to the first edge after which res_valid is seen high.
  task automatic run_job(input vec_t v, output int cyc, output int bad_rdy,
                         output int hold_bad, output logic done);
    int hs0, gap_ctr;
    a_in = v.a; b_in = v.b;
    hs0 = hs_cnt; gap_ctr = 0; bad_rdy = 0; hold_bad = 0; cyc = 0; done = 1'b0;
    @(negedge clk); start = 1'b1; in_valid = 1'b1;
    while (!done && cyc < 2000) begin
      @(posedge clk); cyc++;
      @(negedge clk); start = 1'b0;
      if (res_valid) done = 1'b1;
      else begin
        if (v.force_at > 0 && hs_cnt - hs0 == v.force_at) force_tc = 1'b1;
        if (v.gap_len > 0 && hs_cnt - hs0 == v.gap_after && gap_ctr < v.gap_len) begin
          if (gap_ctr > 0 && !in_ready) bad_rdy++;
          in_valid = 1'b0;
          if (in_ready) gap_ctr++;
        end else in_valid = 1'b1;
      end
    end
    force_tc = 1'b0; in_valid = 1'b0;
    // result must stay put while the consumer stalls; start in HOLD is ignored
    for (int i = 0; i < v.hold_wait; i++) begin
      start = (i == 2);
      @(posedge clk); @(negedge clk);
      if (!res_valid) hold_bad++;
    end
    start = 1'b0;
    res_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    res_ready = 1'b0;
  endtask

  task automatic do_vec(input string tag, input vec_t v);
    int cyc, bad_rdy, hold_bad, acc0, out0;
    logic done;
    acc0 = acc_cnt; out0 = out_cnt;
    run_job(v, cyc, bad_rdy, hold_bad, done);
    chk({tag, ".done"}, done, 1);
    chk({tag, ".cycles"}, cyc, v.exp_cyc);
    chk({tag, ".out_q"}, out_q, v.exp_out);
    chk({tag, ".count_last"}, count_last, v.exp_last);
    chk({tag, ".err"}, err, v.exp_err);
    chk({tag, ".ld_acc_n"}, acc_cnt - acc0, v.exp_acc);
    chk({tag, ".ld_out_n"}, out_cnt - out0, 1);
    chk({tag, ".idle_after"}, busy, 0);
    if (v.gap_len > 0)   chk({tag, ".gap_ready"}, bad_rdy, 0);
    if (v.hold_wait > 0) chk({tag, ".hold_stable"}, hold_bad, 0);
  endtask

  vec_t vt[6];
  vec_t v11;

  initial begin
    int hs0, out0, k;
    //       a    b   gap  len frc hold out      last cyc  acc err
    vt[0] = '{8'd2,   8'd3,   0, 0,  0, 0, 300,     50, 153, 50, 1'b0};
    vt[1] = '{8'd255, 8'd255, 0, 0,  0, 0, 3251250, 50, 153, 50, 1'b0};
    vt[2] = '{8'd2,   8'd3,   7, 10, 0, 0, 300,     50, 163, 50, 1'b0};
    vt[3] = '{8'd7,   8'd11,  0, 0,  0, 5, 3850,    50, 153, 50, 1'b0};
    vt[4] = '{8'd0,   8'd9,   0, 0,  0, 0, 0,       50, 153, 50, 1'b0};
    vt[5] = '{8'd3,   8'd4,   0, 0, 10, 0, 120,     10, 33,  10, 1'b1};
    v11   = '{8'd1,   8'd1,   0, 0,  0, 0, 50,      50, 153, 50, 1'b0};

    // reset state
    #12;
    chk("reset.outs", {in_ready, ld_a, ld_b, ld_acc, ld_out, count_en, ld_count,
                       dp_clr, busy, res_valid, err}, 0);
    @(negedge clk); reset_n = 1'b1;
    @(negedge clk);
    chk("post_reset.busy", busy, 0);

    // abort at pair 20: CLEAR pulse, back to IDLE, no result
    hs0 = hs_cnt; out0 = out_cnt; k = 0;
    a_in = 8'd5; b_in = 8'd5;
    @(negedge clk); start = 1'b1; in_valid = 1'b1;
    @(posedge clk); @(negedge clk); start = 1'b0;
    while (!(in_ready && hs_cnt - hs0 == 19) && k < 500) begin
      @(posedge clk); @(negedge clk); k++;
    end
    chk("abort.reach20", k < 500, 1);
    abort = 1'b1;
    @(posedge clk); @(negedge clk);
    abort = 1'b0; in_valid = 1'b0;
    chk("abort.dp_clr", dp_clr, 1);
    @(posedge clk); @(negedge clk);
    chk("abort.idle", busy, 0);
    chk("abort.dp_clr_low", dp_clr, 0);
    repeat (3) begin @(posedge clk); @(negedge clk); end
    chk("abort.no_res_valid", res_valid, 0);
    chk("abort.no_ld_out", out_cnt - out0, 0);
    do_vec("after_abort", v11);

    // main table; the forced-tc row goes last since err is sticky
    for (int i = 0; i < 6; i++) do_vec($sformatf("vec%0d", i), vt[i]);
    repeat (2) begin @(posedge clk); @(negedge clk); end
    chk("err.sticky", err, 1);

    // asynchronous reset in the middle of a job
    a_in = 8'd1; b_in = 8'd1;
    @(negedge clk); start = 1'b1; in_valid = 1'b1;
    @(posedge clk); @(negedge clk); start = 1'b0;
    repeat (12) begin @(posedge clk); @(negedge clk); end
    chk("midjob.busy", busy, 1);
    #1 reset_n = 1'b0;
    #1;
    chk("async_reset.outs", {in_ready, ld_a, ld_b, ld_acc, ld_out, count_en, ld_count,
                             dp_clr, busy, res_valid, err}, 0);
    in_valid = 1'b0;
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("after_reset.idle", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
